// File: rtl/block_copy_ctrl.sv
// block_copy_ctrl: copies len words from a source memory with RD_LAT-cycle read latency to a destination RAM.
// Optional abort/aborted ports are compiled in when COPY_ABORT_EN is defined.
module block_copy_ctrl #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W:0]   wr_count
`ifdef COPY_ABORT_EN
  ,
  input  logic              abort,
  output logic              aborted
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   rd_k_q, rd_k_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic [RD_LAT-1:0] pipe_v;
  logic [ADDR_W-1:0] pipe_off [RD_LAT];
  logic              pipe_busy;
  logic              abort_req;

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign rd_en    = (state_q == ISSUE);
  assign rd_addr  = rd_en ? src_q + rd_k_q[ADDR_W-1:0] : '0;
  assign wr_en    = pipe_v[RD_LAT-1];
  assign wr_addr  = wr_en ? dst_q + pipe_off[RD_LAT-1] : '0;
  assign wr_data  = wr_en ? rd_data : '0;
  assign wr_count = cnt_q;

`ifdef COPY_ABORT_EN
  logic aborted_q, aborted_d;

  assign abort_req = abort && ((state_q == ISSUE) || (state_q == DRAIN));
  assign aborted   = aborted_q;

  always_comb begin
    aborted_d = aborted_q;
    if (state_q == DONE) begin
      aborted_d = 1'b0;
    end else if (abort_req) begin
      aborted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= aborted_d;
    end
  end
`else
  assign abort_req = 1'b0;
`endif

  // Read-to-write pipeline: each stage carries {valid, destination offset}.
  // An abort squashes every stage at the same edge the FSM moves to DONE.
  for (genvar i = 0; i < RD_LAT; i++) begin : g_pipe
    logic              v_in;
    logic [ADDR_W-1:0] off_in;
    logic              v_q;
    logic [ADDR_W-1:0] off_q;

    if (i == 0) begin : g_head
      assign v_in   = rd_en;
      assign off_in = rd_k_q[ADDR_W-1:0];
    end else begin : g_tail
      assign v_in   = pipe_v[i-1];
      assign off_in = pipe_off[i-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        off_q <= '0;
      end else begin
        v_q   <= v_in & ~abort_req;
        off_q <= off_in;
      end
    end

    assign pipe_v[i]   = v_q;
    assign pipe_off[i] = off_q;
  end

  // The last stage is writing this cycle, so only earlier stages hold DRAIN open.
  if (RD_LAT == 1) begin : g_busy_lat1
    assign pipe_busy = 1'b0;
  end else begin : g_busy_latn
    assign pipe_busy = |pipe_v[RD_LAT-2:0];
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    rd_k_d  = rd_k_q;
    cnt_d   = wr_en ? cnt_q + 1'b1 : cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src_base;
          dst_d   = dst_base;
          len_d   = len;
          rd_k_d  = '0;
          cnt_d   = '0;
          state_d = (len == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        rd_k_d = rd_k_q + 1'b1;
        if (abort_req) begin
          state_d = DONE;
        end else if (rd_k_d == len_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (abort_req || !pipe_busy) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      rd_k_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      rd_k_q  <= rd_k_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
